// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the program sequencer: FSM state encoding,
// halt opcode and instruction counter width.
package cpu_seq_pkg;

    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam int         INSTR_CNT_W = 16;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        NEXT,
        HALTED
    } seq_state_t;

    function automatic logic state_is_busy(input seq_state_t s);
        return !(s == IDLE || s == HALTED);
    endfunction

endpackage

// File: rtl/cpu_program_sequencer.sv
// Fetches instruction words from synchronous program memory and feeds them to
// the CPU one at a time with load/start strobes, honouring the CPU wait flag.
module cpu_program_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int         data_width  = 16,
    parameter int         addr_width  = 8,
    parameter logic [2:0] halt_opcode = HALT_OPCODE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   step,
    output logic                   mem_rd,
    output logic [addr_width-1:0]  mem_addr,
    input  logic [data_width-1:0]  mem_rdata,
    output logic [data_width-1:0]  cpu_in,
    output logic                   cpu_load,
    output logic                   cpu_s,
    input  logic                   cpu_w,
    output logic [addr_width-1:0]  pc,
    output logic                   halted,
    output logic                   busy,
    output logic [INSTR_CNT_W-1:0] instr_count,
    output seq_state_t             dbg_state
);

    // Handshake: the CPU accepts cpu_in on the cycle cpu_load is high, begins
    // execution on the cycle cpu_s is high, and reports completion by taking
    // cpu_w low then high again. Memory data is valid the cycle after mem_rd.

    seq_state_t             state_q, state_d;
    logic [addr_width-1:0]  pc_q, pc_d;
    logic [data_width-1:0]  cpu_in_q, cpu_in_d;
    logic [INSTR_CNT_W-1:0] cnt_q, cnt_d;
    logic                   mem_rd_q, load_q, start_q, busy_q, halted_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cpu_in_d = cpu_in_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE:      if ((run | step) & cpu_w) state_d = FETCH;
            FETCH:     state_d = WAIT_MEM;
            WAIT_MEM: begin
                // A halt word is never forwarded to the CPU nor counted.
                if (mem_rdata[data_width-1 -: 3] == halt_opcode) begin
                    state_d = HALTED;
                end else begin
                    cpu_in_d = mem_rdata;
                    state_d  = LOAD;
                end
            end
            LOAD:      state_d = START;
            START:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (!cpu_w) state_d = WAIT_DONE;
            WAIT_DONE: if (cpu_w) state_d = NEXT;
            NEXT: begin
                pc_d = pc_q + addr_width'(1);
                if (cnt_q != '1) cnt_d = cnt_q + INSTR_CNT_W'(1);
                state_d = run ? FETCH : IDLE;
            end
            HALTED:    state_d = HALTED;
            default:   state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the
    // state they belong to while still coming straight from flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            cpu_in_q <= '0;
            cnt_q    <= '0;
            mem_rd_q <= 1'b0;
            load_q   <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cpu_in_q <= cpu_in_d;
            cnt_q    <= cnt_d;
            mem_rd_q <= (state_d == FETCH);
            load_q   <= (state_d == LOAD);
            start_q  <= (state_d == START);
            busy_q   <= state_is_busy(state_d);
            halted_q <= (state_d == HALTED);
        end
    end

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = pc_q;
    assign cpu_in      = cpu_in_q;
    assign cpu_load    = load_q;
    assign cpu_s       = start_q;
    assign pc          = pc_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule
